// File: rtl/npu_pkg.sv
// Shared NPU definitions: reader FSM state encoding, default element width,
// and the accumulator width derivation used by every MAC stage.
package npu_pkg;

   localparam int NPU_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mac_state_t;

   // Full-precision width: one product plus enough headroom to sum vec_len of them.
   function automatic int acc_width(input int data_width, input int vec_len);
      return 2 * data_width + $clog2(vec_len);
   endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate register: acc <= acc + a*b on acc_en, zeroed by clear.
// One-cycle latency; no backpressure (caller gates clear/acc_en with its advance).
module mac_unit #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 20
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         acc_en,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic signed [ACC_WIDTH-1:0]  acc
);

   logic signed [2*DATA_WIDTH-1:0] prod;

   assign prod = a * b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (acc_en) begin
         acc <= acc + ACC_WIDTH'(prod);
      end
   end

endmodule

// File: rtl/fifo_mac_reader.sv
// Pops VEC_LEN elements from the input FIFO and dot-products them with a local weight file.
// Latency VEC_LEN+1 cycles from start plus one per empty cycle; result held until result_ready.
// RELU_EN: when defined, the presented result is clamped at zero.
module fifo_mac_reader
   import npu_pkg::*;
#(
   parameter int DATA_WIDTH = NPU_DATA_WIDTH,
   parameter int VEC_LEN    = 16,
   parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, VEC_LEN)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       start,
   input  logic                       fifo_empty,
   output logic                       fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]      fifo_data,
   input  logic                       w_wr_en,
   input  logic [$clog2(VEC_LEN)-1:0] w_addr,
   input  logic [DATA_WIDTH-1:0]      w_data,
   output logic [ACC_WIDTH-1:0]       result,
   output logic                       result_valid,
   input  logic                       result_ready,
   output logic                       busy
);

   localparam int IDX_W = $clog2(VEC_LEN);
   localparam int CNT_W = $clog2(VEC_LEN + 1);

   mac_state_t state, state_nxt;

   logic [CNT_W-1:0]      issued;
   logic [IDX_W-1:0]      acc_idx;
   logic                  pending;
   logic [DATA_WIDTH-1:0] weight [VEC_LEN];
   logic                  acc_clear;
   logic                  acc_en;
   logic                  last_pop;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] final_sum;

   assign last_pop = (issued == CNT_W'(VEC_LEN - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else if (enable) begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      fifo_rd_en   = 1'b0;
      acc_clear    = 1'b0;
      busy         = (state != IDLE);
      result_valid = (state == DONE);
      case (state)
         IDLE: begin
            if (start) begin
               acc_clear = enable;
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            fifo_rd_en = !fifo_empty && (issued < CNT_W'(VEC_LEN));
            if (fifo_rd_en && last_pop) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            state_nxt = DONE;
         end
         DONE: begin
            if (result_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Popped data arrives one cycle after the pop edge, so pending marks the
   // cycle in which fifo_data holds a live element to accumulate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issued  <= '0;
         acc_idx <= '0;
         pending <= 1'b0;
      end else if (enable) begin
         pending <= fifo_rd_en;
         if (state == IDLE && start) begin
            issued  <= '0;
            acc_idx <= '0;
         end else begin
            if (fifo_rd_en) begin
               issued <= issued + 1'b1;
            end
            if (pending) begin
               acc_idx <= acc_idx + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < VEC_LEN; i++) begin
            weight[i] <= '0;
         end
      end else if (enable && state == IDLE && w_wr_en) begin
         weight[w_addr] <= w_data;
      end
   end

   assign acc_en = enable && pending;

   mac_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .clear  (acc_clear),
      .acc_en (acc_en),
      .a      (fifo_data),
      .b      (weight[acc_idx]),
      .acc    (acc)
   );

   // The accumulator is untouched from DRAIN until the next start, so it is
   // the latched final sum for the whole DONE window.
`ifdef RELU_EN
   assign final_sum = acc[ACC_WIDTH-1] ? '0 : acc;
`else
   assign final_sum = acc;
`endif

   assign result = result_valid ? final_sum : '0;

endmodule

// File: tb/tb_fifo_mac_reader.sv
// Randomised bench for fifo_mac_reader against a dot-product / latency reference model.
module tb_fifo_mac_reader;

   localparam int DW   = 8;
   localparam int VL   = 16;
   localparam int AW   = 2 * DW + $clog2(VL);
   localparam int AWID = $clog2(VL);

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 enable;
   logic                 start;
   logic                 fifo_empty;
   logic                 fifo_rd_en;
   logic [DW-1:0]        fifo_data;
   logic                 w_wr_en;
   logic [AWID-1:0]      w_addr;
   logic [DW-1:0]        w_data;
   logic signed [AW-1:0] result;
   logic                 result_valid;
   logic                 result_ready;
   logic                 busy;

   fifo_mac_reader #(
      .DATA_WIDTH (DW),
      .VEC_LEN    (VL),
      .ACC_WIDTH  (AW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .start        (start),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_data    (fifo_data),
      .w_wr_en      (w_wr_en),
      .w_addr       (w_addr),
      .w_data       (w_data),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // FIFO model with registered read data, sharing rst and enable with the DUT.
   logic [DW-1:0] q[$];
   logic          push_vld;
   logic [DW-1:0] push_dat;
   int            total_pops = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         fifo_empty <= 1'b1;
         fifo_data  <= '0;
      end else if (enable) begin
         if (fifo_rd_en && q.size() > 0) begin
            fifo_data  <= q.pop_front();
            total_pops <= total_pops + 1;
         end
         if (push_vld) q.push_back(push_dat);
         fifo_empty <= (q.size() == 0);
      end
   end

   // Per-cycle bookkeeping: cycles lost to an empty FIFO or enable=0, and illegal pops.
   int   bub_cnt = 0;
   int   stall_cnt = 0;
   int   viol_cnt = 0;
   logic op_active = 1'b0;
   int   op_base = 0;

   always @(negedge clk) begin
      #1;
      if (fifo_rd_en && fifo_empty) viol_cnt++;
      if (op_active) begin
         if (!enable) stall_cnt++;
         else if (fifo_empty && (total_pops - op_base) < VL) bub_cnt++;
      end
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   int w_m[VL];
   int d_m[VL];

   function automatic longint relu(input longint s);
`ifdef RELU_EN
      return (s < 0) ? 0 : s;
`else
      return s;
`endif
   endfunction

   function automatic longint dot();
      longint s = 0;
      for (int i = 0; i < VL; i++) s += longint'(w_m[i]) * longint'(d_m[i]);
      return s;
   endfunction

   function automatic int rnd8();
      return int'($urandom_range(255)) - 128;
   endfunction

   task automatic load_weights();
      for (int i = 0; i < VL; i++) begin
         @(negedge clk);
         w_wr_en = 1'b1;
         w_addr  = AWID'(i);
         w_data  = DW'(w_m[i]);
      end
      @(negedge clk);
      w_wr_en = 1'b0;
   endtask

   task automatic push_range(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         @(negedge clk);
         push_vld = 1'b1;
         push_dat = DW'(d_m[i]);
      end
      @(negedge clk);
      push_vld = 1'b0;
   endtask

   // mode 0: plain; 1: enable low for 3 cycles mid-FETCH; 2: weight write and start while busy.
   task automatic run_op(input string tag, input int pre, input int gap, input int mode,
                         input int hold);
      longint exp_r;
      int     lat;
      int     b0, s0, v0, p0;
      int     pops_snap;
      exp_r = relu(dot());
      push_range(0, pre);
      b0 = bub_cnt; s0 = stall_cnt; v0 = viol_cnt; p0 = total_pops;
      op_base = total_pops;
      lat = 0;
      pops_snap = 0;
      fork
         begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0; op_active = 1'b1;
            while (!result_valid && lat < 200) begin
               @(negedge clk);
               lat++;
               if (mode == 1) begin
                  if (lat == 4) pops_snap = total_pops;
                  if (lat == 7) chk({tag, " pops during enable=0"}, total_pops - pops_snap, 0);
                  if (lat >= 5 && lat < 7) chk({tag, " busy during enable=0"}, busy, 1);
                  enable = !(lat >= 4 && lat < 7);
               end
               if (mode == 2) begin
                  w_wr_en = (lat == 4);
                  w_addr  = '0;
                  w_data  = 8'd99;
                  start   = (lat == 4 || lat == 5);
               end
            end
            op_active = 1'b0;
         end
         begin
            repeat (gap) @(negedge clk);
            if (pre < VL) push_range(pre, VL);
         end
      join
      chk({tag, " result"}, result, exp_r);
      chk({tag, " latency"}, lat, VL + 1 + (bub_cnt - b0) + (stall_cnt - s0));
      chk({tag, " pop count"}, total_pops - p0, VL);
      chk({tag, " pops while empty"}, viol_cnt - v0, 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (mode == 2) start = (i == 0);
         chk({tag, " valid held"}, result_valid, 1);
         chk({tag, " result held"}, result, exp_r);
      end
      start = 1'b0;
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      chk({tag, " valid after handshake"}, result_valid, 0);
      chk({tag, " busy after handshake"}, busy, 0);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; start = 1'b0; result_ready = 1'b0;
      w_wr_en = 1'b0; w_addr = '0; w_data = '0; push_vld = 1'b0; push_dat = '0;
      repeat (3) @(negedge clk);
      chk("reset result", result, 0);
      chk("reset result_valid", result_valid, 0);
      chk("reset busy", busy, 0);
      chk("reset fifo_rd_en", fifo_rd_en, 0);
      rst = 1'b0;

      for (int i = 0; i < VL; i++) begin w_m[i] = i + 1; d_m[i] = 1; end
      load_weights();
      run_op("basic", VL, 0, 0, 0);
      chk("basic closed form", result_valid ? 0 : relu(dot()), relu(VL * (VL + 1) / 2));

      for (int i = 0; i < VL; i++) begin w_m[i] = -128; d_m[i] = 127; end
      load_weights();
      run_op("neg extreme", VL, 0, 0, 0);

      for (int i = 0; i < VL; i++) d_m[i] = -128;
      run_op("pos extreme", VL, 0, 0, 0);

      for (int i = 0; i < VL; i++) begin w_m[i] = rnd8(); d_m[i] = rnd8(); end
      load_weights();
      run_op("bubble mid", 5, 4, 0, 0);
      run_op("bubble start", 0, 3, 0, 0);

      run_op("busy ignore", VL, 0, 2, 5);
      run_op("weights kept", VL, 0, 0, 0);
      run_op("enable stall", VL, 0, 1, 0);

      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < VL; i++) begin w_m[i] = rnd8(); d_m[i] = rnd8(); end
         load_weights();
         run_op("random", int'($urandom_range(VL)), int'($urandom_range(5)), 0,
                int'($urandom_range(2)));
      end

      for (int i = 0; i < VL; i++) begin w_m[i] = i + 1; d_m[i] = 2; end
      load_weights();
      push_range(0, VL);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid-op reset result", result, 0);
      chk("mid-op reset result_valid", result_valid, 0);
      chk("mid-op reset busy", busy, 0);
      chk("mid-op reset fifo_rd_en", fifo_rd_en, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < VL; i++) begin w_m[i] = 0; d_m[i] = rnd8(); end
      run_op("weights cleared by reset", VL, 0, 0, 0);
      for (int i = 0; i < VL; i++) w_m[i] = rnd8();
      load_weights();
      run_op("fresh after reset", VL, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fifo_mac_reader.md
# fifo_mac_reader

Downstream consumer of the NPU input FIFO. It pops a vector of VEC_LEN signed elements from the FIFO and multiply-accumulates each one against a locally stored signed weight vector. It then presents the dot product on a valid/ready result port. It absorbs the FIFO's one-cycle registered read latency and tolerates the FIFO running empty mid-vector.

## Interface
- DATA_WIDTH, 8, element and weight width (signed two's complement)
- VEC_LEN, 16, elements per dot product (≥2)
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(VEC_LEN), accumulator/result width (signed)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  global advance; must be the same net that drives the FIFO's enable
- start  in  1  request one dot-product operation
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  pop request to FIFO
- fifo_data  in  DATA_WIDTH  FIFO data_out, valid the cycle after a pop edge
- w_wr_en  in  1  weight write strobe
- w_addr  in  $clog2(VEC_LEN)  weight index
- w_data  in  DATA_WIDTH  weight value
- result  out  ACC_WIDTH  dot-product result
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- busy  out  1  high in any state other than IDLE

## Operation
- **States.** IDLE, FETCH, DRAIN, DONE. Encoding is 2-bit.
- **Enable.** When enable=0, every register holds (state, counters, pending, accumulator, result, weights).
- **IDLE**
  - On start=1 with enable=1: clear the accumulator and the issue count, then go to FETCH.
  - A weight write is accepted only in IDLE: weight[w_addr] <= w_data. A weight write in any other state is ignored.
- **FETCH**
  - fifo_rd_en = !fifo_empty && issued < VEC_LEN. This is combinational from registered state and the flag.
  - Each edge with fifo_rd_en && enable increments issued and sets pending=1. Otherwise pending=0.
  - When pending=1, the accumulator adds fifo_data × weight[k]. k is the accumulate index, 0..VEC_LEN-1 in pop order.
  - Go to DRAIN on the edge that issues pop VEC_LEN-1 (issued reaches VEC_LEN).
- **DRAIN**
  - fifo_rd_en=0.
  - Accumulate the final pending element.
  - Latch result from the final sum, then go to DONE.
- **DONE**
  - result_valid=1 and result is held stable.
  - On result_valid && result_ready && enable, go to IDLE. result_valid drops the next cycle.
  - start is ignored in every state except IDLE.
- **Arithmetic**
  - Products are signed DATA_WIDTH×DATA_WIDTH, sign-extended to ACC_WIDTH.
  - ACC_WIDTH is sized so that no overflow is possible. No saturation logic.
- **Reset**
  - State=IDLE, fifo_rd_en=0, result=0, result_valid=0, busy=0, accumulator=0, all weights=0.
  - Reset mid-operation discards partial sums. The FIFO shares rst, so no popped data is orphaned.

## Timing
- Back-to-back pops when the FIFO is non-empty: one per cycle.
- Latency from the start-sampling edge E0, with no empty bubbles:
  - pops issue at E1..E_VEC_LEN
  - the last accumulate is at E_VEC_LEN+1
  - result_valid is high after E_VEC_LEN+1
- Each cycle fifo_empty=1 during FETCH adds exactly one cycle of latency.
- Minimum period between successive start acceptances is VEC_LEN+3 cycles: one IDLE cycle follows the handshake.

## Configuration
- **RELU_EN defined:** result latches max(sum, 0). Negative sums produce 0.
- **RELU_EN undefined:** result latches the raw signed sum.
- No other behaviour differs between the two builds.

## Structure
- **npu_pkg** (shared package) holds:
  - the state localparams (IDLE=0, FETCH=1, DRAIN=2, DONE=3)
  - the default DATA_WIDTH
  - the ACC_WIDTH derivation, reused by later stages
- **mac_unit** (sub-module) is a signed multiply plus accumulator register.
  - Inputs: clk, rst, clear, acc_en, a, b.
  - Output: acc.
  - The FSM, counters, weight file and handshake stay in fifo_mac_reader.

## Test plan
- **Basic dot product.** VEC_LEN=4, weights {1,2,3,4}, FIFO preloaded {1,1,1,1}, start → result=10. result_valid rises 5 cycles after the start-sampling edge. Exactly 4 fifo_rd_en cycles.
- **Negative extreme.** VEC_LEN=16, weights all -128, data all 127 → result=-260096. With RELU_EN defined → result=0.
- **Positive extreme.** Weights all -128, data all -128 (VEC_LEN=16) → result=262144. No overflow.
- **Empty bubbles.** FIFO starts with 2 of 4 elements; the remaining 2 are written 3 cycles later → correct sum. fifo_rd_en is never high while fifo_empty=1. Latency grows by exactly the bubble count.
- **Back-pressure and enable.** result_ready held low for 5 cycles → result and result_valid are stable throughout. Weight writes and start during busy are ignored. enable=0 for 3 cycles mid-FETCH → no pops and no state change.
- **Reset mid-operation.** rst asserted after 2 of 4 accumulates → all outputs and weights read 0. A fresh operation after reset produces the correct sum.
